apb_master_arbiter: RTL and testbench
=====================================

// Module: apb_master_arbiter
// PURPOSE
//  Shares one APB master port among NUM_REQ local requesters (CPU, DMA, debug) in front of apb_slave.
//  Round-robin arbitration; winner's transfer runs as a standard APB SETUP->ACCESS sequence.
//  Holds ACCESS until PREADY or a wait-state timeout, then returns read data/status to the winner.
// PARAMETERS
//  NUM_REQ  2   number of requesters (2..8)
//  ADDR_W   32  PADDR / req address width
//  DATA_W   32  PWDATA / PRDATA width
//  TIMEOUT  16  max ACCESS cycles with PREADY low before abort (>=1)
// PORTS
//  PCLK       in   1               single clock, rising edge
//  PRESET     in   1               asynchronous, active-high reset
//  req_valid  in   NUM_REQ         request pending; held until req_ready for that index
//  req_write  in   NUM_REQ         1=write, 0=read
//  req_addr   in   NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata  in   NUM_REQ*DATA_W  packed write data
//  req_ready  out  NUM_REQ         one-hot pulse, request captured
//  rsp_valid  out  NUM_REQ         one-hot 1-cycle pulse, transfer complete
//  rsp_rdata  out  DATA_W          read data, valid with rsp_valid
//  rsp_err    out  1               1 = timeout abort, valid with rsp_valid
//  PSEL       out  1               APB select
//  PENABLE    out  1               APB enable
//  PWRITE     out  1               APB direction
//  PADDR      out  ADDR_W          APB address
//  PWDATA     out  DATA_W          APB write data
//  PRDATA     in   DATA_W          APB read data
//  PREADY     in   1               APB ready
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, rr pointer=0, timeout counter=0; abort in-flight transfer, no rsp.
//  FSM registered outputs:
//   IDLE: any req_valid -> pick first set index at/after rr pointer; pulse req_ready[g]; latch
//     write/addr/wdata; next SETUP. No request -> stay, PSEL=0.
//   SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from latch -> ACCESS.
//   ACCESS: PSEL=1, PENABLE=1, controls stable. PREADY=1 -> rsp_valid[g]=1 next cycle,
//     rsp_rdata=PRDATA if read else 0, rsp_err=0; go IDLE. PREADY=0 -> counter++;
//     counter==TIMEOUT-1 with PREADY=0 -> drop PSEL/PENABLE, rsp_valid[g]=1, rsp_err=1, rdata=0.
//  Latency: req_valid (IDLE) -> PSEL 1 cycle; zero-wait transfer rsp_valid 3 cycles after req_ready.
//  Back-to-back: PSEL deasserts >=1 cycle (IDLE) between transfers; max 1 transfer per 3 cycles.
//  rr pointer updates to g+1 (mod NUM_REQ) on each grant; wraps NUM_REQ-1 -> 0.
//  Requests arriving during SETUP/ACCESS wait; req_valid drop before req_ready is ignored-safe.
//  Same requester may re-request the cycle after its rsp_valid; no starvation: every valid
//  requester served within NUM_REQ grants.
//  PADDR/PWDATA/PWRITE hold last value when idle; only PSEL/PENABLE return to 0.
// STRUCTURE
//  apb_pkg: state enum {IDLE,SETUP,ACCESS}, APB phase constants, default ADDR_W/DATA_W.
//  Sub-module rr_arbiter (NUM_REQ): req vector + pointer -> one-hot grant + index,
//  combinational, reusable. Top holds FSM, latch, timeout counter.
// TESTING
//  Single write req0 addr 0x00 data 0xDEADBEEF, PREADY=1 -> PSEL 1 cycle SETUP, 1 cycle ACCESS,
//   PWDATA=0xDEADBEEF, rsp_valid[0], rsp_err=0.
//  Read req1 addr 0x00 after write, slave returns 0xDEADBEEF -> rsp_rdata=0xDEADBEEF with rsp_valid[1].
//  req0 and req1 held continuously, 4 transfers -> grant order 0,1,0,1; IDLE gap between each.
//  PREADY low 3 cycles -> ACCESS lasts 4 cycles, controls stable, rsp_err=0.
//  PREADY stuck low, TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0.
//  PRESET pulsed mid-ACCESS -> PSEL/PENABLE=0 same edge, no rsp_valid, next req granted from index 0.

Source files
------------

// File: rtl/apb_master_arbiter_pkg.sv
// apb_master_arbiter_pkg: shared types, APB phase encodings and round-robin helpers
package apb_master_arbiter_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    typedef struct packed {
        logic psel;
        logic penable;
    } apb_phase_t;
    localparam apb_phase_t PH_IDLE   = '{psel: 1'b0, penable: 1'b0};
    localparam apb_phase_t PH_SETUP  = '{psel: 1'b1, penable: 1'b0};
    localparam apb_phase_t PH_ACCESS = '{psel: 1'b1, penable: 1'b1};
    function automatic int rr_wrap(int s, int n);
        return s >= n ? s - n : s;
    endfunction
    function automatic int rr_next(int g, int n);
        return rr_wrap(g + 1, n);
    endfunction
endpackage

// File: rtl/apb_master_arbiter_if.sv
// apb_master_arbiter_if: APB bus between the arbiter (master) and one slave
interface apb_master_arbiter_if
    import apb_master_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY);
    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);
    localparam int IDX_W = $clog2(NUM_REQ);
    // scan offsets from farthest to nearest so the nearest set request wins
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (req[IDX_W'(rr_wrap(int'(ptr) + k, NUM_REQ))]) begin
                idx = IDX_W'(rr_wrap(int'(ptr) + k, NUM_REQ));
                any = 1'b1;
            end
        gnt = any ? NUM_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter: round-robin sharing of one APB master port among NUM_REQ requesters
module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    apb_master_arbiter_if.master      apb
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    state_t             state, state_n;
    apb_phase_t         ph_n;
    logic [IDX_W-1:0]   gidx, gidx_n, ptr, ptr_n, win_idx;
    logic [NUM_REQ-1:0] win_gnt, rsp_valid_n;
    logic               win_any, pwrite_n, rsp_err_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [ADDR_W-1:0]  paddr_n;
    logic [DATA_W-1:0]  pwdata_n, rsp_rdata_n;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req(req_valid), .ptr(ptr), .gnt(win_gnt), .idx(win_idx), .any(win_any)
    );

    assign req_ready = (state == IDLE && !PRESET) ? win_gnt : '0;

    // next state, latched request and registered APB/response outputs
    always_comb begin
        state_n     = state;
        gidx_n      = gidx;
        ptr_n       = ptr;
        cnt_n       = '0;
        ph_n        = PH_IDLE;
        pwrite_n    = apb.PWRITE;
        paddr_n     = apb.PADDR;
        pwdata_n    = apb.PWDATA;
        rsp_valid_n = '0;
        rsp_rdata_n = '0;
        rsp_err_n   = 1'b0;
        case (state)
            IDLE: if (win_any) begin
                state_n  = SETUP;
                gidx_n   = win_idx;
                ptr_n    = IDX_W'(rr_next(int'(win_idx), NUM_REQ));
                ph_n     = PH_SETUP;
                pwrite_n = req_write[win_idx];
                paddr_n  = req_addr[win_idx*ADDR_W +: ADDR_W];
                pwdata_n = req_wdata[win_idx*DATA_W +: DATA_W];
            end
            SETUP: begin
                state_n = ACCESS;
                ph_n    = PH_ACCESS;
            end
            ACCESS: if (apb.PREADY) begin
                state_n           = IDLE;
                rsp_valid_n[gidx] = 1'b1;
                rsp_rdata_n       = apb.PWRITE ? '0 : apb.PRDATA;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                state_n           = IDLE;
                rsp_valid_n[gidx] = 1'b1;
                rsp_err_n         = 1'b1;
            end else begin
                cnt_n = cnt + 1'b1;
                ph_n  = PH_ACCESS;
            end
            default: state_n = IDLE;
        endcase
    end

    // state and output registers; reset aborts any in-flight transfer silently
    always_ff @(posedge PCLK or posedge PRESET)
        if (PRESET) begin
            state       <= IDLE;
            gidx        <= '0;
            ptr         <= '0;
            cnt         <= '0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state       <= state_n;
            gidx        <= gidx_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
            apb.PSEL    <= ph_n.psel;
            apb.PENABLE <= ph_n.penable;
            apb.PWRITE  <= pwrite_n;
            apb.PADDR   <= paddr_n;
            apb.PWDATA  <= pwdata_n;
            rsp_valid   <= rsp_valid_n;
            rsp_rdata   <= rsp_rdata_n;
            rsp_err     <= rsp_err_n;
        end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter: directed table, corner sequences and random traffic against a reference model
module tb_apb_master_arbiter;
    localparam int N = 3, AW = 32, DW = 32, TO = 16;

    logic          PCLK = 1'b0, PRESET = 1'b1;
    logic [N-1:0]  req_valid = '0, req_write = '0, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    apb_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .apb(bus)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0, passed = 0;

    // slave: memory with a configurable number of PREADY-low cycles per transfer
    logic [DW-1:0] mem [16];
    int acc_cnt, cur_wait, wait_cfg = 0;
    bit rand_wait = 1'b0;
    assign bus.PRDATA = mem[bus.PADDR[5:2]];
    assign bus.PREADY = bus.PSEL && bus.PENABLE && acc_cnt >= cur_wait;
    always @(posedge PCLK or posedge PRESET)
        if (PRESET) begin
            acc_cnt  <= 0;
            cur_wait <= 0;
            for (int k = 0; k < 16; k++) mem[k] <= '0;
        end else begin
            acc_cnt <= (bus.PSEL && bus.PENABLE && !bus.PREADY) ? acc_cnt + 1 : 0;
            if (bus.PSEL && !bus.PENABLE) cur_wait <= rand_wait ? int'($urandom_range(0, 20)) : wait_cfg;
            if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) mem[bus.PADDR[5:2]] <= bus.PWDATA;
        end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic reset_pulse();
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    typedef struct packed {
        int          idx;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        bit          err;
    } vec_t;

    task automatic run_one(input vec_t v);
        int n, exp_acc;
        exp_acc = v.waits >= TO ? TO : v.waits + 1;
        @(negedge PCLK);
        wait_cfg = v.waits;
        req_valid[v.idx] = 1'b1;
        req_write[v.idx] = v.wr;
        req_addr[v.idx*AW +: AW] = v.addr;
        req_wdata[v.idx*DW +: DW] = v.wdata;
        #1 chk("req_ready", req_ready, 64'(1) << v.idx);
        @(negedge PCLK);
        req_valid[v.idx] = 1'b0;
        chk("setup_phase", {bus.PSEL, bus.PENABLE}, 2'b10);
        chk("paddr", bus.PADDR, v.addr);
        chk("pwrite", bus.PWRITE, v.wr);
        if (v.wr) chk("pwdata", bus.PWDATA, v.wdata);
        n = 0;
        @(negedge PCLK);
        while (bus.PSEL && bus.PENABLE && n < 40) begin
            n++;
            chk("access_ctl", {bus.PADDR, bus.PWRITE}, {v.addr, v.wr});
            chk("no_early_rsp", rsp_valid, 0);
            @(negedge PCLK);
        end
        chk("access_cycles", n, exp_acc);
        chk("rsp_valid", rsp_valid, 64'(1) << v.idx);
        chk("rsp_rdata", rsp_rdata, v.rdata);
        chk("rsp_err", rsp_err, v.err);
        chk("idle_psel", {bus.PSEL, bus.PENABLE}, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [7];
        int got, last, cyc, ptr, g, age, cur_g;
        bit busy, cur_wr, err;
        logic [31:0] cur_a, cur_d, exp_d;
        logic [31:0] ref_mem [16];
        logic [N-1:0] last_ready, exp_rdy, exp_rsp;

        vt[0] = '{0, 1'b1, 32'h00, 32'hDEADBEEF, 0,  32'h0,        1'b0};
        vt[1] = '{1, 1'b0, 32'h00, 32'h0,        0,  32'hDEADBEEF, 1'b0};
        vt[2] = '{2, 1'b1, 32'h10, 32'h12345678, 3,  32'h0,        1'b0};
        vt[3] = '{0, 1'b0, 32'h10, 32'h0,        1,  32'h12345678, 1'b0};
        vt[4] = '{1, 1'b0, 32'h04, 32'h0,        99, 32'h0,        1'b1};
        vt[5] = '{2, 1'b1, 32'h04, 32'h0000A5A5, 15, 32'h0,        1'b0};
        vt[6] = '{1, 1'b0, 32'h04, 32'h0,        0,  32'h0000A5A5, 1'b0};

        req_valid = 3'b001;
        @(negedge PCLK);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_apb_ctl", {bus.PSEL, bus.PENABLE, bus.PWRITE}, 3'b000);
        chk("rst_paddr", bus.PADDR, 0);
        chk("rst_pwdata", bus.PWDATA, 0);
        chk("rst_rsp", {rsp_valid, rsp_err}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        @(negedge PCLK);
        PRESET = 1'b0;
        req_valid = '0;

        foreach (vt[i]) run_one(vt[i]);

        // two requesters held continuously: strict alternation, one IDLE cycle between transfers
        reset_pulse();
        wait_cfg = 0;
        req_write = '0;
        req_addr = '0;
        req_valid = 3'b011;
        got = 0;
        last = 0;
        cyc = 0;
        while (got < 4 && cyc < 60) begin
            #1;
            if (|req_ready) begin
                chk("rr_grant", req_ready, 64'(1) << (got % 2));
                chk("rr_idle_gap", bus.PSEL, 0);
                if (got > 0) chk("rr_spacing", cyc - last, 3);
                last = cyc;
                got++;
            end
            @(negedge PCLK);
            cyc++;
        end
        chk("rr_count", got, 4);
        req_valid = '0;
        repeat (5) @(negedge PCLK);

        // reset during ACCESS: bus drops at once, no response, pointer back to 0
        reset_pulse();
        wait_cfg = 10;
        req_valid = 3'b010;
        #1 chk("pre_rst_grant", req_ready, 3'b010);
        @(negedge PCLK);
        req_valid = '0;
        repeat (2) @(negedge PCLK);
        chk("mid_access", {bus.PSEL, bus.PENABLE}, 2'b11);
        PRESET = 1'b1;
        #1 chk("rst_drop_bus", {bus.PSEL, bus.PENABLE}, 2'b00);
        @(negedge PCLK);
        PRESET = 1'b0;
        wait_cfg = 0;
        for (int k = 0; k < 20; k++) begin
            chk("no_rsp_after_rst", rsp_valid, 0);
            @(negedge PCLK);
        end
        req_valid = 3'b110;
        #1 chk("grant_after_rst", req_ready, 3'b010);
        @(negedge PCLK);
        req_valid = '0;
        repeat (6) @(negedge PCLK);

        // random traffic checked cycle by cycle against a transaction-level model
        reset_pulse();
        rand_wait = 1'b1;
        for (int k = 0; k < 16; k++) ref_mem[k] = '0;
        busy = 1'b0;
        ptr = 0;
        age = 0;
        cur_g = 0;
        cur_wr = 1'b0;
        cur_a = '0;
        cur_d = '0;
        last_ready = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge PCLK);
            req_valid &= ~last_ready;
            if (c < 500)
                for (int i = 0; i < N; i++)
                    if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                        req_valid[i] = 1'b1;
                        req_write[i] = 1'($urandom_range(0, 1));
                        req_addr[i*AW +: AW] = 32'($urandom_range(0, 15) * 4);
                        req_wdata[i*DW +: DW] = $urandom;
                    end
            #1;
            if (busy) age++;
            exp_rsp = '0;
            if (busy && age >= 2 && age == 2 + (cur_wait >= TO ? TO : cur_wait + 1))
                exp_rsp = N'(1) << cur_g;
            chk("rnd_rsp_valid", rsp_valid, exp_rsp);
            if (exp_rsp != 0) begin
                err = cur_wait >= TO;
                exp_d = (err || cur_wr) ? 32'h0 : ref_mem[cur_a[5:2]];
                chk("rnd_rsp_err", rsp_err, err);
                chk("rnd_rsp_rdata", rsp_rdata, exp_d);
                if (!err && cur_wr) ref_mem[cur_a[5:2]] = cur_d;
                busy = 1'b0;
            end
            exp_rdy = '0;
            g = -1;
            if (!busy)
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(ptr + k) % N]) g = (ptr + k) % N;
            if (g >= 0) exp_rdy = N'(1) << g;
            chk("rnd_req_ready", req_ready, exp_rdy);
            if (g >= 0) begin
                busy = 1'b1;
                age = 0;
                cur_g = g;
                cur_wr = req_write[g];
                cur_a = req_addr[g*AW +: AW];
                cur_d = req_wdata[g*DW +: DW];
                ptr = (g + 1) % N;
            end
            last_ready = req_ready;
        end
        chk("rnd_drained", {busy, req_valid}, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
